// File: rtl/clk_div_monitor_pkg.sv
// Shared types and defaults for the divided-clock monitor.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_e;

    localparam int DEF_CW       = 8;
    localparam int DEF_LOCK_CNT = 4;

    function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Measurement bus: the stimulus side drives div_in/clr_err, the monitor reports results.
interface clk_div_monitor_if #(
    parameter int CW = 8
);
    logic          div_in;
    logic          clr_err;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          locked;
    logic          err;

    modport master (
        output div_in, clr_err,
        input  period, high_time, valid, locked, err
    );

    modport slave (
        input  div_in, clr_err,
        output period, high_time, valid, locked, err
    );
endinterface

// File: rtl/clk_div_monitor_sync_edge_det.sv
// Two-flop synchronizer plus history flop; exposes the synchronized level and a rise pulse.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise
);
    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_din;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high time of an asynchronous divided clock and declares lock after
// LOCK_CNT consecutive in-tolerance periods; err is sticky on loss of lock or timeout.
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int EXP_DIV  = 3,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    clk_div_monitor_if.slave   bus
);
    localparam int            MW       = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_CNT);

    logic          w_level;
    logic          w_rise;
    logic          w_match;
    logic          w_timeout;
    logic          w_meas;
    logic          w_err_set;
    state_e        w_state_nxt;
    logic [MW-1:0] w_match_nxt;

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_hcnt;
    logic [MW-1:0] r_match;
    logic [CW-1:0] r_period;
    logic [CW-1:0] r_high;
    logic          r_valid;
    logic          r_locked;
    logic          r_err;

    sync_edge_det u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_din   (bus.div_in),
        .o_level (w_level),
        .o_rise  (w_rise)
    );

    assign w_match   = abs_diff(32'(r_cnt), EXP_DIV) <= TOL;
    assign w_timeout = !w_rise && (r_cnt == CNT_MAX);

    // Counters restart on every rise so a new period counts the edge cycle as its first.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else if (w_rise) begin
            r_cnt  <= CW'(1);
            r_hcnt <= CW'(1);
        end else begin
            if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
            if (w_level && r_hcnt != CNT_MAX)
                r_hcnt <= r_hcnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_meas      = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                w_match_nxt = '0;
                if (w_rise)
                    w_state_nxt = ACQ;
            end
            ACQ: begin
                if (w_rise) begin
                    w_meas = 1'b1;
                    if (w_match) begin
                        w_match_nxt = r_match + 1'b1;
                        if (MW'(r_match + 1'b1) == LOCK_TGT)
                            w_state_nxt = LOCK;
                    end else begin
                        w_match_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                    w_match_nxt = '0;
                    w_err_set   = 1'b1;
                end
            end
            LOCK: begin
                if (w_rise) begin
                    w_meas = 1'b1;
                    if (!w_match) begin
                        w_state_nxt = ACQ;
                        w_match_nxt = '0;
                        w_err_set   = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                    w_match_nxt = '0;
                    w_err_set   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_match_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_match  <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_match  <= w_match_nxt;
            r_valid  <= w_meas;
            r_locked <= (w_state_nxt == LOCK);
            if (w_meas) begin
                r_period <= r_cnt;
                r_high   <= r_hcnt;
            end
            // A simultaneous clear loses to a new error.
            if (w_err_set)
                r_err <= 1'b1;
            else if (bus.clr_err)
                r_err <= 1'b0;
        end
    end

    assign bus.period    = r_period;
    assign bus.high_time = r_high;
    assign bus.valid     = r_valid;
    assign bus.locked    = r_locked;
    assign bus.err       = r_err;
endmodule
